// File: rtl/exec_stage_mc.sv
// exec_stage_mc: execute stage with operand forwarding, single-cycle ALU ops,
// an iterative shift-add multiply, and branch resolution with next-slot squash.
module exec_stage_mc #(
  parameter int WIDTH   = 16,
  parameter int RADDR_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         op,
  input  logic               is_reg_write,
  input  logic               is_branch,
  input  logic               is_halt,
  input  logic [WIDTH-1:0]   val1,
  input  logic [WIDTH-1:0]   val2,
  input  logic [WIDTH-1:0]   val3,
  input  logic [1:0]         fwd1_sel,
  input  logic [1:0]         fwd2_sel,
  input  logic [WIDTH-1:0]   mem_value,
  output logic               out_valid,
  output logic [WIDTH-1:0]   result,
  output logic               do_reg_write,
  output logic [RADDR_W-1:0] reg_addr,
  output logic               do_branch,
  output logic [WIDTH-1:0]   branch_address,
  output logic               do_halt
);
  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = SH_W + 1;
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3;
  localparam logic [2:0] OP_GT  = 3'd4, OP_EQ  = 3'd5, OP_MUL = 3'd6, OP_SHL = 3'd7;

  typedef enum logic {IDLE, MUL} state_t;
  state_t state_reg, state_next;

  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] mcand_reg, mplier_reg, acc_reg, mul_dst_reg;
  logic             mul_rw_reg, mul_br_reg;
  logic             pend_valid_reg, pend_rw_reg, pend_br_reg;
  logic [WIDTH-1:0] pend_result_reg, pend_dst_reg;
  logic             halt_q;

  logic                  mul_last, take, take_mul, take_alu;
  logic [1:0][WIDTH-1:0] opnd;
  logic [WIDTH-1:0]      alu_res, acc_step;
  logic                  fin_valid, fin_rw, fin_br;
  logic [WIDTH-1:0]      fin_result, fin_dst;

  // An instruction issued in the final multiply cycle completes one cycle after
  // the product, so intake pauses while that held result drains.
  assign mul_last = (state_reg == MUL) && (cnt_reg == CNT_W'(1));
  assign in_ready = ((state_reg == IDLE) && !pend_valid_reg) || mul_last;
  assign take     = in_valid && in_ready && !do_branch;
  assign take_mul = take && (op == OP_MUL);
  assign take_alu = take && (op != OP_MUL);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
      logic [1:0]       sel;
      logic [WIDTH-1:0] raw;
      assign sel = (gi == 0) ? fwd1_sel : fwd2_sel;
      assign raw = (gi == 0) ? val1 : val2;
      assign opnd[gi] = (sel == 2'd0) ? raw :
                        (sel == 2'd1) ? result :
                        (sel == 2'd2) ? mem_value : '0;
    end
  endgenerate

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = opnd[0] + opnd[1];
      OP_SUB:  alu_res = opnd[0] - opnd[1];
      OP_AND:  alu_res = opnd[0] & opnd[1];
      OP_OR:   alu_res = opnd[0] | opnd[1];
      OP_GT:   alu_res = {{(WIDTH-1){1'b0}}, opnd[0] > opnd[1]};
      OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, opnd[0] == opnd[1]};
      OP_SHL:  alu_res = opnd[0] << opnd[1][SH_W-1:0];
      default: alu_res = '0;
    endcase
  end

  assign acc_step = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (take_mul) state_next = MUL;
      MUL:  if (mul_last) state_next = take_mul ? MUL : IDLE;
    endcase
  end

  always_comb begin
    fin_valid  = 1'b0;
    fin_result = alu_res;
    fin_rw     = is_reg_write;
    fin_br     = is_branch;
    fin_dst    = val3;
    if (mul_last) begin
      fin_valid  = 1'b1;
      fin_result = acc_step;
      fin_rw     = mul_rw_reg;
      fin_br     = mul_br_reg;
      fin_dst    = mul_dst_reg;
    end else if (pend_valid_reg) begin
      fin_valid  = 1'b1;
      fin_result = pend_result_reg;
      fin_rw     = pend_rw_reg;
      fin_br     = pend_br_reg;
      fin_dst    = pend_dst_reg;
    end else if (take_alu) begin
      fin_valid  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg     <= '0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      acc_reg     <= '0;
      mul_rw_reg  <= 1'b0;
      mul_br_reg  <= 1'b0;
      mul_dst_reg <= '0;
    end else if (take_mul) begin
      cnt_reg     <= CNT_W'(WIDTH);
      mcand_reg   <= opnd[0];
      mplier_reg  <= opnd[1];
      acc_reg     <= '0;
      mul_rw_reg  <= is_reg_write;
      mul_br_reg  <= is_branch;
      mul_dst_reg <= val3;
    end else if (state_reg == MUL) begin
      cnt_reg    <= cnt_reg - CNT_W'(1);
      acc_reg    <= acc_step;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_valid_reg  <= 1'b0;
      pend_rw_reg     <= 1'b0;
      pend_br_reg     <= 1'b0;
      pend_result_reg <= '0;
      pend_dst_reg    <= '0;
    end else begin
      pend_valid_reg <= mul_last && take_alu;
      if (mul_last && take_alu) begin
        pend_rw_reg     <= is_reg_write;
        pend_br_reg     <= is_branch;
        pend_result_reg <= alu_res;
        pend_dst_reg    <= val3;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid      <= 1'b0;
      result         <= '0;
      do_reg_write   <= 1'b0;
      reg_addr       <= '0;
      do_branch      <= 1'b0;
      branch_address <= '0;
      halt_q         <= 1'b1;
      do_halt        <= 1'b1;
    end else begin
      out_valid    <= fin_valid;
      do_reg_write <= fin_valid && fin_rw && !fin_br;
      do_branch    <= fin_valid && fin_br && (fin_result != '0);
      halt_q       <= take && is_halt;
      do_halt      <= halt_q;
      if (fin_valid) begin
        result         <= fin_result;
        reg_addr       <= fin_dst[RADDR_W-1:0];
        branch_address <= fin_dst;
      end
    end
  end
endmodule

// File: tb/tb_exec_stage_mc.sv
// Bench for exec_stage_mc: directed table, multi-cycle corner sequences and
// randomized instructions checked against an arithmetic reference model.
module tb_exec_stage_mc;
  localparam int WIDTH   = 16;
  localparam int RADDR_W = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               in_valid, in_ready;
  logic [2:0]         op;
  logic               is_reg_write, is_branch, is_halt;
  logic [WIDTH-1:0]   val1, val2, val3, mem_value;
  logic [1:0]         fwd1_sel, fwd2_sel;
  logic               out_valid, do_reg_write, do_branch, do_halt;
  logic [WIDTH-1:0]   result, branch_address;
  logic [RADDR_W-1:0] reg_addr;

  exec_stage_mc #(.WIDTH(WIDTH), .RADDR_W(RADDR_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .is_reg_write(is_reg_write), .is_branch(is_branch), .is_halt(is_halt),
    .val1(val1), .val2(val2), .val3(val3), .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel),
    .mem_value(mem_value), .out_valid(out_valid), .result(result),
    .do_reg_write(do_reg_write), .reg_addr(reg_addr), .do_branch(do_branch),
    .branch_address(branch_address), .do_halt(do_halt)
  );

  always #5 clk = ~clk;

  int   n_vec = 0, n_miscmp = 0;
  logic hq_m = 1'b1, dh_m = 1'b1;

  typedef struct {
    logic [2:0]       op;
    logic [WIDTH-1:0] a, b, dst;
    logic             rw, br;
    logic [WIDTH-1:0] exp_res;
    logic             exp_rw, exp_br;
  } vec_t;
  vec_t tbl [14];

  task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock edge; acc_halt says a non-squashed halting instruction is taken at it.
  task automatic tick(input logic acc_halt);
    @(posedge clk);
    dh_m = hq_m;
    hq_m = acc_halt;
    #1;
    check("do_halt", do_halt, dh_m);
  endtask

  task automatic drive(input logic [2:0] o, input logic [WIDTH-1:0] v1, input logic [WIDTH-1:0] v2,
                       input logic [WIDTH-1:0] v3, input logic [1:0] f1, input logic [1:0] f2,
                       input logic [WIDTH-1:0] mv, input logic rw, input logic br, input logic hl);
    in_valid = 1'b1; op = o; val1 = v1; val2 = v2; val3 = v3;
    fwd1_sel = f1; fwd2_sel = f2; mem_value = mv;
    is_reg_write = rw; is_branch = br; is_halt = hl;
  endtask

  task automatic idle_in();
    in_valid = 1'b0; is_halt = 1'b0; is_branch = 1'b0; is_reg_write = 1'b0;
  endtask

  function automatic logic [WIDTH-1:0] ref_op(input int o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] p;
    p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    case (o)
      0: return a + b;
      1: return a - b;
      2: return a & b;
      3: return a | b;
      4: return (a > b) ? 1 : 0;
      5: return (a == b) ? 1 : 0;
      6: return p[WIDTH-1:0];
      default: return a << (b % WIDTH);
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] fwd(input logic [1:0] s, input logic [WIDTH-1:0] v,
                                           input logic [WIDTH-1:0] mv, input logic [WIDTH-1:0] prev);
    case (s)
      2'd0: return v;
      2'd1: return prev;
      2'd2: return mv;
      default: return '0;
    endcase
  endfunction

  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_v1, r_v2, r_v3, r_mv, r_a, r_b, r_exp, res_m;
  logic [1:0]       r_f1, r_f2;
  logic             r_rw, r_br, r_hl, br_m, squash, seen;
  int               lat;

  initial begin
    idle_in();
    op = 3'd0; val1 = '0; val2 = '0; val3 = '0; fwd1_sel = 2'd0; fwd2_sel = 2'd0; mem_value = '0;

    tbl[0]  = '{3'd0, 16'd5,    16'd7,    16'd3,  1'b1, 1'b0, 16'h000C, 1'b1, 1'b0};
    tbl[1]  = '{3'd1, 16'd3,    16'd5,    16'd4,  1'b1, 1'b0, 16'hFFFE, 1'b1, 1'b0};
    tbl[2]  = '{3'd2, 16'hF0F0, 16'h3C3C, 16'd5,  1'b1, 1'b0, 16'h3030, 1'b1, 1'b0};
    tbl[3]  = '{3'd3, 16'hF000, 16'h000F, 16'd6,  1'b0, 1'b0, 16'hF00F, 1'b0, 1'b0};
    tbl[4]  = '{3'd4, 16'd8,    16'd3,    16'd7,  1'b1, 1'b0, 16'h0001, 1'b1, 1'b0};
    tbl[5]  = '{3'd4, 16'd3,    16'd8,    16'd8,  1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[6]  = '{3'd4, 16'hFFFF, 16'd1,    16'd9,  1'b1, 1'b0, 16'h0001, 1'b1, 1'b0};
    tbl[7]  = '{3'd5, 16'd4,    16'd4,    16'h40, 1'b1, 1'b1, 16'h0001, 1'b0, 1'b1};
    tbl[8]  = '{3'd5, 16'd4,    16'd5,    16'h44, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0};
    tbl[9]  = '{3'd7, 16'd1,    16'h13,   16'd10, 1'b1, 1'b0, 16'h0008, 1'b1, 1'b0};
    tbl[10] = '{3'd7, 16'h8001, 16'd1,    16'd11, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0};
    tbl[11] = '{3'd0, 16'hFFFF, 16'd1,    16'd12, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[12] = '{3'd1, 16'd0,    16'd1,    16'd13, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    tbl[13] = '{3'd5, 16'h1234, 16'h1234, 16'd14, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0};

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_valid", out_valid, 0);
    check("rst_in_halt", do_halt, 1);
    rst = 1'b1;
    check("rst_result", result, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_reg_write", do_reg_write, 0);
    check("rst_reg_addr", reg_addr, 0);
    check("rst_branch", do_branch, 0);
    check("rst_baddr", branch_address, 0);
    check("rst_ready", in_ready, 1);
    hq_m = 1'b1; dh_m = 1'b1;
    tick(0);
    tick(0);

    // Table of single-cycle operations
    foreach (tbl[i]) begin
      drive(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].dst, 2'd0, 2'd0, '0, tbl[i].rw, tbl[i].br, 1'b0);
      tick(0);
      idle_in();
      check($sformatf("tbl%0d_valid", i), out_valid, 1);
      check($sformatf("tbl%0d_result", i), result, tbl[i].exp_res);
      check($sformatf("tbl%0d_rw", i), do_reg_write, tbl[i].exp_rw);
      check($sformatf("tbl%0d_br", i), do_branch, tbl[i].exp_br);
      if (tbl[i].exp_br) check($sformatf("tbl%0d_baddr", i), branch_address, tbl[i].dst);
      else               check($sformatf("tbl%0d_raddr", i), reg_addr, tbl[i].dst[RADDR_W-1:0]);
      tick(0);
      check($sformatf("tbl%0d_drop", i), out_valid, 0);
    end

    // Result forwarding, back to back
    drive(3'd0, 16'd5, 16'd7, 16'd3, 2'd0, 2'd0, '0, 1'b1, 1'b0, 1'b0);
    tick(0);
    drive(3'd0, 16'hDEAD, 16'd1, 16'd3, 2'd1, 2'd0, '0, 1'b1, 1'b0, 1'b0);
    check("fwd_first", result, 16'd12);
    check("fwd_first_rw", do_reg_write, 1);
    tick(0);
    idle_in();
    check("fwd_second", result, 16'd13);
    check("fwd_second_rw", do_reg_write, 1);
    check("fwd_second_addr", reg_addr, 4'd3);
    tick(0);

    // Memory forwarding, shl and reserved selector
    drive(3'd7, 16'hBEEF, 16'd4, 16'd1, 2'd2, 2'd0, 16'h0003, 1'b1, 1'b0, 1'b0);
    tick(0);
    check("mem_shl", result, 16'h0030);
    drive(3'd2, 16'hFFFF, 16'h0, 16'd1, 2'd0, 2'd2, 16'h1234, 1'b1, 1'b0, 1'b0);
    tick(0);
    check("mem_and", result, 16'h1234);
    drive(3'd0, 16'd9, 16'd100, 16'd1, 2'd0, 2'd3, 16'h1234, 1'b1, 1'b0, 1'b0);
    tick(0);
    idle_in();
    check("fwd_reserved", result, 16'd9);
    tick(0);

    // Multiply with back-to-back issue in its final cycle
    drive(3'd6, 16'd300, 16'd300, 16'd7, 2'd0, 2'd0, '0, 1'b1, 1'b0, 1'b0);
    tick(0);
    idle_in();
    lat = 0;
    seen = 1'b0;
    while (!in_ready && lat < 40) begin
      if (out_valid) seen = 1'b1;
      lat++;
      tick(0);
    end
    check("mul_ready_low", lat, 15);
    check("mul_no_early", seen, 0);
    drive(3'd0, 16'd2, 16'd3, 16'd5, 2'd0, 2'd0, '0, 1'b1, 1'b0, 1'b0);
    tick(0);
    idle_in();
    check("mul_valid", out_valid, 1);
    check("mul_result", result, 16'h5F90);
    check("mul_rw", do_reg_write, 1);
    check("mul_addr", reg_addr, 4'd7);
    tick(0);
    check("b2b_valid", out_valid, 1);
    check("b2b_result", result, 16'd5);
    check("b2b_addr", reg_addr, 4'd5);
    tick(0);
    check("b2b_drop", out_valid, 0);

    // Taken branch squashes the next slot, including a halt and a mul
    drive(3'd5, 16'd4, 16'd4, 16'h40, 2'd0, 2'd0, '0, 1'b1, 1'b1, 1'b0);
    tick(0);
    check("br_taken", do_branch, 1);
    check("br_addr", branch_address, 16'h40);
    check("br_rw", do_reg_write, 0);
    drive(3'd0, 16'd1, 16'd1, 16'd2, 2'd0, 2'd0, '0, 1'b1, 1'b0, 1'b1);
    tick(0);
    idle_in();
    check("sq_valid", out_valid, 0);
    check("sq_result", result, 16'd1);
    check("sq_rw", do_reg_write, 0);
    check("sq_branch", do_branch, 0);
    tick(0);
    drive(3'd5, 16'd9, 16'd9, 16'h22, 2'd0, 2'd0, '0, 1'b0, 1'b1, 1'b0);
    tick(0);
    drive(3'd6, 16'd3, 16'd3, 16'd1, 2'd0, 2'd0, '0, 1'b1, 1'b0, 1'b0);
    tick(0);
    idle_in();
    check("sqmul_ready", in_ready, 1);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid) seen = 1'b1;
      tick(0);
    end
    check("sqmul_silent", seen, 0);

    // Halt passes through two registers
    drive(3'd0, 16'd2, 16'd2, 16'd1, 2'd0, 2'd0, '0, 1'b1, 1'b0, 1'b1);
    tick(1);
    idle_in();
    check("halt_add", result, 16'd4);
    tick(0);
    tick(0);

    // Reset five cycles into a multiply
    drive(3'd6, 16'd11, 16'd13, 16'd2, 2'd0, 2'd0, '0, 1'b1, 1'b0, 1'b0);
    tick(0);
    idle_in();
    repeat (5) tick(0);
    #2 rst = 1'b0;
    #1;
    check("rmul_valid", out_valid, 0);
    check("rmul_ready", in_ready, 1);
    check("rmul_result", result, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    hq_m = 1'b1; dh_m = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid) seen = 1'b1;
      tick(0);
    end
    check("rmul_silent", seen, 0);
    check("rmul_ready_after", in_ready, 1);

    // Randomized instructions against the reference model
    res_m = '0;
    br_m  = 1'b0;
    for (int t = 0; t < 200; t++) begin
      int nidle;
      nidle = $urandom_range(0, 2);
      for (int k = 0; k < nidle; k++) begin
        tick(0);
        br_m = 1'b0;
      end
      r_op = 3'($urandom_range(0, 7));
      r_v1 = WIDTH'($urandom);
      r_v2 = ($urandom_range(0, 3) == 0) ? r_v1 : WIDTH'($urandom);
      r_v3 = WIDTH'($urandom);
      r_mv = WIDTH'($urandom);
      r_f1 = 2'($urandom_range(0, 3));
      r_f2 = 2'($urandom_range(0, 3));
      r_rw = 1'($urandom_range(0, 1));
      r_br = ($urandom_range(0, 2) == 0);
      r_hl = ($urandom_range(0, 5) == 0);
      r_a  = fwd(r_f1, r_v1, r_mv, res_m);
      r_b  = fwd(r_f2, r_v2, r_mv, res_m);
      r_exp = ref_op(r_op, r_a, r_b);
      squash = br_m;
      check("rnd_ready", in_ready, 1);
      drive(r_op, r_v1, r_v2, r_v3, r_f1, r_f2, r_mv, r_rw, r_br, r_hl);
      tick(r_hl && !squash);
      idle_in();
      if (squash) begin
        check("rnd_sq_valid", out_valid, 0);
        check("rnd_sq_ready", in_ready, 1);
        check("rnd_sq_result", result, res_m);
        br_m = 1'b0;
      end else begin
        if (r_op == 3'd6) begin
          check("rnd_mul_busy", in_ready, 0);
          lat = 0;
          while (!out_valid && lat < 3 * WIDTH) begin
            tick(0);
            lat++;
          end
          check("rnd_mul_lat", lat, WIDTH);
        end
        check("rnd_valid", out_valid, 1);
        check("rnd_result", result, r_exp);
        check("rnd_rw", do_reg_write, r_rw && !r_br);
        check("rnd_br", do_branch, r_br && (r_exp != 0));
        if (r_br && (r_exp != 0)) check("rnd_baddr", branch_address, r_v3);
        else                      check("rnd_raddr", reg_addr, r_v3[RADDR_W-1:0]);
        res_m = r_exp;
        br_m  = r_br && (r_exp != 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end
endmodule
